// File: rtl/cacheline_adaptor_pkg.sv
// cacheline_adaptor_pkg: shared widths, derived burst geometry and FSM state type.
// Used by the cache-line and burst interfaces and by the adaptor itself.
package cacheline_adaptor_pkg;

    localparam int LINE_W  = 256;
    localparam int BURST_W = 64;
    localparam int ADDR_W  = 32;
    localparam int BEATS   = LINE_W / BURST_W;
    localparam int OFS     = $clog2(LINE_W / 8);
    localparam int CNT_W   = $clog2(BEATS);

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        RESP
    } ca_state_t;

endpackage

// File: rtl/cacheline_adaptor_if.sv
// cacheline_adaptor_if: bus bundles on either side of the adaptor.
// cacheline_line_if : cache pmem port (addr/read/write/wdata from the cache,
//                     rdata/resp back to it); the cache is the master.
// cacheline_burst_if: burst memory port (addr/read/write/wdata to memory,
//                     rdata/resp from it); the adaptor is the master.
interface cacheline_line_if;
    import cacheline_adaptor_pkg::*;
    logic [ADDR_W-1:0] addr;
    logic              read;
    logic              write;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] rdata;
    logic              resp;
    modport master (output addr, read, write, wdata, input rdata, resp);
    modport slave  (input addr, read, write, wdata, output rdata, resp);
endinterface

interface cacheline_burst_if;
    import cacheline_adaptor_pkg::*;
    logic [ADDR_W-1:0]  addr;
    logic               read;
    logic               write;
    logic [BURST_W-1:0] wdata;
    logic [BURST_W-1:0] rdata;
    logic               resp;
    modport master (output addr, read, write, wdata, input rdata, resp);
    modport slave  (input addr, read, write, wdata, output rdata, resp);
endinterface

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: turns one cache line read/write into a BEATS-beat burst.
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - asynchronous active-low reset
//   line - cache side (slave): addr/read/write/wdata in, rdata/resp out
//   mem  - memory side (master): addr/read/write/wdata out, rdata/resp in
module cacheline_adaptor
    import cacheline_adaptor_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    cacheline_line_if.slave    line,
    cacheline_burst_if.master  mem
);

    ca_state_t          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LINE_W-1:0]  wline_q, wline_d;
    logic [LINE_W-1:0]  rline_q, rline_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic               resp_q, resp_d;
    logic               last;

    assign last = cnt_q == CNT_W'(BEATS - 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        rline_d = rline_q;
        case (state_q)
            IDLE: begin
                // write has priority when the cache raises both
                if (line.write || line.read) begin
                    state_d = line.write ? WR_BURST : RD_BURST;
                    addr_d  = {line.addr[ADDR_W-1:OFS], {OFS{1'b0}}};
                    wline_d = line.wdata;
                    cnt_d   = '0;
                end
            end
            RD_BURST: begin
                if (mem.resp) begin
                    rline_d[BURST_W*cnt_q +: BURST_W] = mem.rdata;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = last ? RESP : RD_BURST;
                end
            end
            WR_BURST: begin
                if (mem.resp) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = last ? RESP : WR_BURST;
                end
            end
            default: state_d = IDLE;
        endcase
        // outputs follow the next state so they are registered yet cycle-aligned
        rd_d   = state_d == RD_BURST;
        wr_d   = state_d == WR_BURST;
        resp_d = state_d == RESP;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            rline_q <= rline_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            resp_q  <= resp_d;
        end
    end

    assign mem.addr   = addr_q;
    assign mem.read   = rd_q;
    assign mem.write  = wr_q;
    assign mem.wdata  = wline_q[BURST_W*cnt_q +: BURST_W];
    assign line.rdata = rline_q;
    assign line.resp  = resp_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor: directed table-driven bench for cacheline_adaptor.
module tb_cacheline_adaptor;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [255:0] last_rd = '0;

    always #5 clk = ~clk;

    cacheline_line_if  line();
    cacheline_burst_if mem();

    cacheline_adaptor dut (
        .clk  (clk),
        .rst  (rst),
        .line (line),
        .mem  (mem)
    );

    typedef struct {
        logic         rd;
        logic         wr;
        logic [31:0]  addr;
        logic [31:0]  exp_addr;
        logic [255:0] data;
        logic [15:0]  pat;
        int           exp_cyc;
    } txn_t;

    txn_t tv[6];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // cycle 1 is the first cycle after the acceptance edge; pat bit i drives mem_resp in cycle i+1
    task automatic run_txn(input txn_t t);
        int   cyc;
        int   k;
        bit   done;
        logic exp_rd;
        exp_rd = t.rd && !t.wr;
        @(negedge clk);
        line.addr  = t.addr;
        line.read  = t.rd;
        line.write = t.wr;
        line.wdata = t.data;
        @(posedge clk);
        cyc  = 0;
        k    = 0;
        done = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            line.addr  = ~t.addr;
            line.wdata = ~t.data;
            mem.resp   = 1'b0;
            if (line.resp) begin
                chk("resp_cycle", 256'(cyc), 256'(t.exp_cyc));
                chk("beat_count", 256'(k), 256'd4);
                chk("rd_drop", 256'(mem.read), 256'd0);
                chk("wr_drop", 256'(mem.write), 256'd0);
                line.read  = 1'b0;
                line.write = 1'b0;
                mem.resp   = 1'b1;
                done       = 1;
            end else begin
                chk("mem_addr", 256'(mem.addr), 256'(t.exp_addr));
                chk("mem_read", 256'(mem.read), 256'(exp_rd));
                chk("mem_write", 256'(mem.write), 256'(!exp_rd));
                if (cyc <= 16 && k < 4 && t.pat[cyc-1]) begin
                    mem.resp = 1'b1;
                    if (exp_rd) mem.rdata = t.data[64*k +: 64];
                    else chk("mem_wdata", 256'(mem.wdata), 256'(t.data[64*k +: 64]));
                    k++;
                end
            end
        end
        if (!done) chk("resp_timeout", 256'd0, 256'd1);
        @(negedge clk);
        mem.resp = 1'b0;
        chk("resp_once", 256'(line.resp), 256'd0);
        chk("idle_rd", 256'(mem.read), 256'd0);
        chk("idle_wr", 256'(mem.write), 256'd0);
        if (exp_rd) last_rd = t.data;
        chk("line_rdata", line.rdata, last_rd);
    endtask

    initial begin
        tv[0] = '{1'b1, 1'b0, 32'h1234_5678, 32'h1234_5660,
                  {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, 16'b1111, 5};
        tv[1] = '{1'b0, 1'b1, 32'h0000_0040, 32'h0000_0040,
                  {{16{4'hD}}, 64'hD2D2_0000_2222_D2D2, 64'hD1D1_1111_0000_D1D1, 64'hD0D0_0123_4567_89AB},
                  16'b1111, 5};
        tv[2] = '{1'b1, 1'b0, 32'h0000_1FFF, 32'h0000_1FE0,
                  {64'hCAFE_0000_0000_0003, 64'hCAFE_0000_0000_0002, 64'hCAFE_0000_0000_0001, 64'hCAFE_0000_0000_0000},
                  16'b1101001, 8};
        tv[3] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFE0,
                  {64'h0BAD_F00D_0000_0003, 64'h0BAD_F00D_0000_0002, 64'h0BAD_F00D_0000_0001, 64'h0BAD_F00D_0000_0000},
                  16'b11011, 6};
        tv[4] = '{1'b0, 1'b1, 32'h0000_1FE4, 32'h0000_1FE0,
                  {64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0},
                  16'b1010101, 8};
        tv[5] = '{1'b1, 1'b0, 32'h8000_0020, 32'h8000_0020,
                  {64'h0000_0000_0000_0004, 64'h0000_0000_0000_0003, 64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001},
                  16'b1111, 5};

        line.addr  = '0;
        line.read  = 1'b0;
        line.write = 1'b0;
        line.wdata = '0;
        mem.rdata  = '0;
        mem.resp   = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_mem_read", 256'(mem.read), 256'd0);
        chk("rst_mem_write", 256'(mem.write), 256'd0);
        chk("rst_mem_addr", 256'(mem.addr), 256'd0);
        chk("rst_line_resp", 256'(line.resp), 256'd0);
        chk("rst_line_rdata", line.rdata, 256'd0);
        chk("rst_mem_wdata", 256'(mem.wdata), 256'd0);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) run_txn(tv[i]);

        // mem_resp pulses while idle must not advance the beat counter
        @(negedge clk);
        mem.resp  = 1'b1;
        mem.rdata = 64'hDEAD_DEAD_DEAD_DEAD;
        @(negedge clk);
        run_txn(tv[0]);

        // asynchronous reset after two captured beats abandons the burst
        @(negedge clk);
        line.addr = 32'h0000_0100;
        line.read = 1'b1;
        @(posedge clk);
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            mem.resp  = 1'b1;
            mem.rdata = 64'h7777_7777_7777_7777;
        end
        @(posedge clk);
        #2;
        rst       = 1'b0;
        line.read = 1'b0;
        mem.resp  = 1'b0;
        #1;
        chk("mid_rst_mem_read", 256'(mem.read), 256'd0);
        chk("mid_rst_mem_addr", 256'(mem.addr), 256'd0);
        chk("mid_rst_line_rdata", line.rdata, 256'd0);
        chk("mid_rst_line_resp", 256'(line.resp), 256'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("mid_rst_no_resp", 256'(line.resp), 256'd0);
        end
        rst     = 1'b1;
        last_rd = '0;
        @(negedge clk);
        chk("post_rst_no_resp", 256'(line.resp), 256'd0);
        run_txn(tv[2]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
